// File: rtl/human_entry_detector.sv
// Doorway beam-break front end for the occupancy counter.
// Beam A is outside the door and beam B is inside.
// Each raw beam is synchronized and then debounced.
// An FSM decodes the order in which the beams break:
//   A, AB, B, clear -> entry pulse
//   B, AB, A, clear -> exit pulse
// Any other ordering, a back-out or a stalled sequence produces no pulse.
// A stalled sequence times out into WAIT_CLEAR and raises fault.
module human_entry_detector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_a_raw,
  input  logic beam_b_raw,
  output logic human_detected,
  output logic exit_detected,
  output logic busy,
  output logic fault
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_IN1        = 3'd1;
  localparam logic [2:0] S_IN2        = 3'd2;
  localparam logic [2:0] S_IN3        = 3'd3;
  localparam logic [2:0] S_OUT1       = 3'd4;
  localparam logic [2:0] S_OUT2       = 3'd5;
  localparam logic [2:0] S_OUT3       = 3'd6;
  localparam logic [2:0] S_WAIT_CLEAR = 3'd7;

  // Bit 0 holds beam A and bit 1 holds beam B.
  logic [1:0]       w_raw;
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic [1:0]       w_deb;
  logic             w_a;
  logic             w_b;
  logic [2:0]       r_state;
  logic [2:0]       w_fsm_next;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_timeout;
  logic             r_human;
  logic             r_exit;
  logic             r_fault;

  assign w_raw = {beam_b_raw, beam_a_raw};

  // Two-flop synchronizer for both asynchronous beam inputs.
  // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_deb
    logic [DB_W-1:0] r_cnt;
    logic            r_lvl;

    // Accept a new level only after it has held for DEBOUNCE_CYCLES edges.
    // Any bounce back to the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync[ch] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt >= DB_W'(DEBOUNCE_CYCLES)) begin
        r_lvl <= r_sync[ch];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[ch] = r_lvl;
  end

  assign w_a = w_deb[0];
  assign w_b = w_deb[1];

  // Next-state decode on the debounced levels; the timeout override is applied separately.
  // NOTE: next state is defaulted first so that no path through the case infers a latch.
  always_comb begin
    w_fsm_next = r_state;
    case (r_state)
      S_IDLE: begin
        case ({w_a, w_b})
          2'b10:   w_fsm_next = S_IN1;
          2'b01:   w_fsm_next = S_OUT1;
          2'b11:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_IDLE;
        endcase
      end
      S_IN1: begin
        case ({w_a, w_b})
          2'b11:   w_fsm_next = S_IN2;
          2'b00:   w_fsm_next = S_IDLE;
          2'b01:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_IN1;
        endcase
      end
      S_IN2: begin
        case ({w_a, w_b})
          2'b01:   w_fsm_next = S_IN3;
          2'b10:   w_fsm_next = S_IN1;
          2'b00:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_IN2;
        endcase
      end
      S_IN3: begin
        case ({w_a, w_b})
          2'b00:   w_fsm_next = S_IDLE;
          2'b11:   w_fsm_next = S_IN2;
          2'b10:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_IN3;
        endcase
      end
      S_OUT1: begin
        case ({w_a, w_b})
          2'b11:   w_fsm_next = S_OUT2;
          2'b00:   w_fsm_next = S_IDLE;
          2'b10:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_OUT1;
        endcase
      end
      S_OUT2: begin
        case ({w_a, w_b})
          2'b10:   w_fsm_next = S_OUT3;
          2'b01:   w_fsm_next = S_OUT1;
          2'b00:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_OUT2;
        endcase
      end
      S_OUT3: begin
        case ({w_a, w_b})
          2'b00:   w_fsm_next = S_IDLE;
          2'b11:   w_fsm_next = S_OUT2;
          2'b01:   w_fsm_next = S_WAIT_CLEAR;
          default: w_fsm_next = S_OUT3;
        endcase
      end
      default: begin
        if (!w_a && !w_b) w_fsm_next = S_IDLE;
      end
    endcase
  end

  // Fires on the edge where the dwell count would reach TIMEOUT_CYCLES.
  // A genuine transition on that same edge wins over the timeout.
  assign w_timeout = (r_state != S_IDLE) && (w_fsm_next == r_state) &&
                     (r_tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

  // Dwell counter for the current non-IDLE state; it saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_IDLE || w_fsm_next != r_state || w_timeout) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt < TMO_W'(TIMEOUT_CYCLES)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // State register and the registered outputs.
  // Each pulse is raised on the same edge as its terminating transition.
  // NOTE: every register, including the debounce and timeout counters, has an async clear so a mid-sequence reset can never leak a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_human <= 1'b0;
      r_exit  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_timeout ? S_WAIT_CLEAR : w_fsm_next;
      r_human <= !w_timeout && (r_state == S_IN3)  && (w_fsm_next == S_IDLE);
      r_exit  <= !w_timeout && (r_state == S_OUT3) && (w_fsm_next == S_IDLE);
      if (w_timeout) begin
        r_fault <= 1'b1;
      end else if (r_state == S_WAIT_CLEAR && w_fsm_next == S_IDLE) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign human_detected = r_human;
  assign exit_detected  = r_exit;
  assign fault          = r_fault;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_human_entry_detector.sv
// Directed bench for human_entry_detector with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
// A table of timed beam phases is applied in a loop and checked per phase.
// Hand-written sequences cover pulse latency, timeout timing and reset mid-sequence.
module tb_human_entry_detector;

  localparam int DEB = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic reset;
  logic beam_a_raw;
  logic beam_b_raw;
  logic human_detected;
  logic exit_detected;
  logic busy;
  logic fault;

  int total   = 0;
  int bad     = 0;
  int both_hi = 0;

  typedef struct {
    logic a;
    logic b;
    int   cycles;
    logic exp_busy;      // busy level sampled after the last edge of the phase
    logic exp_fault;     // fault level sampled after the last edge of the phase
    int   exp_h;         // human_detected high cycles seen during the phase
    int   exp_e;         // exit_detected high cycles seen during the phase
    logic exp_busy_any;  // busy seen high at any point during the phase
  } vec_t;

  vec_t vecs[$];

  human_entry_detector #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .beam_a_raw    (beam_a_raw),
    .beam_b_raw    (beam_b_raw),
    .human_detected(human_detected),
    .exit_detected (exit_detected),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic b, input int n,
                              input logic eb, input logic ef, input int eh,
                              input int ee, input logic ebany);
    vec_t v;
    v.a = a;
    v.b = b;
    v.cycles = n;
    v.exp_busy = eb;
    v.exp_fault = ef;
    v.exp_h = eh;
    v.exp_e = ee;
    v.exp_busy_any = ebany;
    return v;
  endfunction

  // Drive the beams just after a falling edge, then sample after each of n rising edges.
  task automatic drive_hold(input logic a, input logic b, input int n,
                            output int h, output int e, output logic bany);
    h = 0;
    e = 0;
    bany = 1'b0;
    beam_a_raw = a;
    beam_b_raw = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (human_detected) h++;
      if (exit_detected) e++;
      if (busy) bany = 1'b1;
      if (human_detected && exit_detected) both_hi++;
    end
  endtask

  initial begin
    int   h;
    int   e;
    logic bany;
    int   first;
    int   cnt;

    // Entry sequence: A, AB, B, clear.
    vecs.push_back(mk(1, 0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20, 0, 0, 1, 0, 1));
    // Exit sequence: B, AB, A, clear.
    vecs.push_back(mk(0, 1, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20, 0, 0, 0, 1, 1));
    // Glitches: A high for 3 cycles, ten times; each is shorter than the debounce window.
    for (int g = 0; g < 10; g++) begin
      vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0));
    end
    // Back-out from IN1.
    vecs.push_back(mk(1, 0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20, 0, 0, 0, 0, 1));
    // A, AB, A, clear: returns to IN1 and then backs out.
    vecs.push_back(mk(1, 0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 20, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20, 0, 0, 0, 0, 1));
    // Stuck B: times out into WAIT_CLEAR with fault, then clears on release.
    vecs.push_back(mk(0, 1, 200, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 20, 0, 0, 0, 0, 1));

    reset = 1'b1;
    beam_a_raw = 1'b0;
    beam_b_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_fault", fault, 0);
    check("reset_human", human_detected, 0);
    check("reset_exit", exit_detected, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_hold(vecs[i].a, vecs[i].b, vecs[i].cycles, h, e, bany);
      check($sformatf("row%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("row%0d_fault", i), fault, vecs[i].exp_fault);
      check($sformatf("row%0d_human_cycles", i), h, vecs[i].exp_h);
      check($sformatf("row%0d_exit_cycles", i), e, vecs[i].exp_e);
      check($sformatf("row%0d_busy_seen", i), bany, vecs[i].exp_busy_any);
    end

    // Entry latency: the pulse appears after edge 2+DEB+1 = 7 following the release.
    drive_hold(1, 0, 20, h, e, bany);
    drive_hold(1, 1, 20, h, e, bany);
    drive_hold(0, 1, 20, h, e, bany);
    beam_a_raw = 1'b0;
    beam_b_raw = 1'b0;
    first = -1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (human_detected) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (exit_detected) both_hi++;
    end
    check("entry_latency_edge", first, 2 + DEB + 1);
    check("entry_pulse_cycles", cnt, 1);

    // Timeout timing: OUT1 is entered on edge 7 and fault rises 64 edges later.
    beam_b_raw = 1'b1;
    first = -1;
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (fault && first < 0) first = k;
      if (human_detected || exit_detected) cnt++;
    end
    check("fault_rise_edge", first, 2 + DEB + 1 + TMO);
    check("stuck_no_pulse", cnt, 0);
    check("stuck_busy", busy, 1);
    beam_b_raw = 1'b0;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!fault && first < 0) first = k;
      if (human_detected || exit_detected) cnt++;
    end
    check("fault_clear_edge", first, 2 + DEB + 1);
    check("release_no_pulse", cnt, 0);
    check("release_busy", busy, 0);

    // Reset while in IN2 clears every output immediately and emits no pulse afterwards.
    drive_hold(1, 0, 20, h, e, bany);
    drive_hold(1, 1, 20, h, e, bany);
    check("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    beam_a_raw = 1'b0;
    beam_b_raw = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_fault", fault, 0);
    check("midreset_human", human_detected, 0);
    check("midreset_exit", exit_detected, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive_hold(0, 0, 20, h, e, bany);
    check("post_reset_busy_seen", bany, 0);
    check("post_reset_human", h, 0);
    check("post_reset_exit", e, 0);

    check("never_both_pulses", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/human_entry_detector.md
Name: human_entry_detector

Overview:
Sensor front-end that sits directly upstream of the occupancy counter. It conditions two raw IR beam-break inputs mounted across a doorway: beam A on the outside, beam B on the inside. It decodes the order in which the beams are broken and emits a single-cycle entry pulse that drives the counter's human_detected input, plus an exit pulse for future decrement logic. Glitches, partial walk-ins and stuck sensors must never produce a pulse.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a synchronized beam level is accepted (1 ms at 50 MHz); minimum 2.
TIMEOUT_CYCLES, 100000000, maximum cycles spent in any non-IDLE state without a state change before a fault is declared (2 s at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
beam_a_raw  input  1  outer beam, 1 = broken; asynchronous to clk
beam_b_raw  input  1  inner beam, 1 = broken; asynchronous to clk
human_detected  output  1  one-cycle pulse per completed entry; feeds the counter
exit_detected  output  1  one-cycle pulse per completed exit
busy  output  1  high whenever the FSM is not in IDLE
fault  output  1  high from timeout until both beams are clear

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. On reset, every register goes to 0: synchronizers, debounce counters, debounced levels a and b, and the timeout counter. State returns to IDLE. All outputs are 0. Reset asserted mid-sequence aborts the sequence with no pulse.
- Synchronizer: each raw input passes through a 2-FF synchronizer.
- Debounce, per channel: the counter clears whenever the synchronized value equals the debounced value. Otherwise it increments. When the synchronized value has differed for DEBOUNCE_CYCLES consecutive edges, the debounced value takes the new level and the counter clears. Any bounce back restarts the count.
- FSM on debounced (a, b):
  - IDLE: a&!b -> IN1; !a&b -> OUT1; a&b -> WAIT_CLEAR.
  - IN1: a&b -> IN2; !a&!b -> IDLE (backed out, no pulse); !a&b -> WAIT_CLEAR.
  - IN2: !a&b -> IN3; a&!b -> IN1; !a&!b -> WAIT_CLEAR.
  - IN3: !a&!b -> IDLE and human_detected=1; a&b -> IN2; a&!b -> WAIT_CLEAR.
  - OUT1/OUT2/OUT3: mirror of IN1/IN2/IN3 with a and b swapped; OUT3 -> IDLE pulses exit_detected.
  - WAIT_CLEAR: !a&!b -> IDLE, with no pulse.
- Pulses: registered, asserted on the same edge as the terminating transition, high for exactly one cycle. Never both high at once. At most one pulse per sequence.
- Latency: raw release in IN3 (raw stable, changed just before edge 0) -> human_detected high after edge 2+DEBOUNCE_CYCLES+1.
- Timeout: the counter clears on every state change and in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES it forces WAIT_CLEAR and sets fault=1, and no pulse is emitted. fault clears on the WAIT_CLEAR -> IDLE transition.
- Counter widths: $clog2(param+1). Counters saturate and never wrap.
- busy: combinational decode of state != IDLE.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Entry: raw A=1; then A=1,B=1; then B only; then both 0, each phase held 20 cycles -> exactly one human_detected pulse, 1 cycle wide, 7 edges after the final release; exit_detected stays 0.
- Exit: the same sequence mirrored (B first) -> exactly one exit_detected pulse; human_detected stays 0.
- Glitch: raw A pulsed high for 3 cycles, 10 times -> debounced a never changes; busy stays 0; no pulses.
- Back-out: A=1 for 20 cycles, then released -> busy high, then low; no pulse. Also A, A&B, A, clear -> no pulse.
- Stuck sensor: B held 1 for 200 cycles -> fault=1 at 64 cycles after entering OUT1, no pulse; B released -> fault=0 and IDLE after debounce.
- Reset mid-op: assert reset while in IN2 -> all outputs 0 immediately; after reset release with both beams clear, IDLE; no pulse.
